// File: rtl/key_capture.sv
`default_nettype none
// ============================================================================
// Module  : key_capture
// Purpose : Accepts debounced keypad strobes, keeps the last two key codes and
//           multiplexes them onto a two-digit active-low 7-segment display.
// Rev     : 1.0  initial release
// ============================================================================
module key_capture #(
  parameter logic [23:0] MUX_DIV = 24'd50000,
  parameter logic [7:0]  DEAD    = 8'd16,
  parameter logic [23:0] LOCKOUT = 24'd250000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] row_pressed,
  input  logic [3:0] col,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output logic       key_valid,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [1:0] S_SHOW_NEW = 2'd0;
  localparam logic [1:0] S_BLANK_A  = 2'd1;
  localparam logic [1:0] S_SHOW_OLD = 2'd2;
  localparam logic [1:0] S_BLANK_B  = 2'd3;

  logic [3:0]  r_digit_new;
  logic [3:0]  r_digit_old;
  logic        r_key_valid;
  logic [23:0] r_lock;
  logic [1:0]  r_state;
  logic [23:0] r_phase;

  logic        w_row_onehot;
  logic        w_col_onehot;
  logic        w_accept;
  logic [1:0]  w_row_idx;
  logic [1:0]  w_col_idx;
  logic [3:0]  w_code;
  logic        w_phase_last;
  logic [3:0]  w_show_digit;
  logic [6:0]  w_seg;

  assign w_row_onehot = (row_pressed != 4'd0) && ((row_pressed & (row_pressed - 4'd1)) == 4'd0);
  assign w_col_onehot = (col != 4'd0) && ((col & (col - 4'd1)) == 4'd0);
  assign w_accept     = enable && w_row_onehot && w_col_onehot && (r_lock == 24'd0);

  // Index encoders are only meaningful when the vector is one-hot.
  assign w_row_idx = {row_pressed[2] | row_pressed[3], row_pressed[1] | row_pressed[3]};
  assign w_col_idx = {col[2] | col[3], col[1] | col[3]};

  always_comb begin
    w_code = 4'h0;
    case ({w_row_idx, w_col_idx})
      4'b00_00: w_code = 4'h1;
      4'b00_01: w_code = 4'h2;
      4'b00_10: w_code = 4'h3;
      4'b00_11: w_code = 4'hA;
      4'b01_00: w_code = 4'h4;
      4'b01_01: w_code = 4'h5;
      4'b01_10: w_code = 4'h6;
      4'b01_11: w_code = 4'hB;
      4'b10_00: w_code = 4'h7;
      4'b10_01: w_code = 4'h8;
      4'b10_10: w_code = 4'h9;
      4'b10_11: w_code = 4'hC;
      4'b11_00: w_code = 4'hE;
      4'b11_01: w_code = 4'h0;
      4'b11_10: w_code = 4'hF;
      4'b11_11: w_code = 4'hD;
      default:  w_code = 4'h0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit_new <= 4'h0;
      r_digit_old <= 4'h0;
      r_key_valid <= 1'b0;
      r_lock      <= 24'd0;
    end else begin
      r_key_valid <= w_accept;
      if (w_accept) begin
        r_digit_old <= r_digit_new;
        r_digit_new <= w_code;
        r_lock      <= LOCKOUT - 24'd1;
      end else if (r_lock != 24'd0) begin
        r_lock <= r_lock - 24'd1;
      end
    end
  end

  // Digit phases run for MUX_DIV cycles, blanking phases for DEAD cycles.
  assign w_phase_last = (r_state == S_SHOW_NEW || r_state == S_SHOW_OLD)
                        ? (r_phase == MUX_DIV - 24'd1)
                        : (r_phase == {16'd0, DEAD} - 24'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_SHOW_NEW;
      r_phase <= 24'd0;
    end else if (w_phase_last) begin
      r_state <= r_state + 2'd1;
      r_phase <= 24'd0;
    end else begin
      r_phase <= r_phase + 24'd1;
    end
  end

  always_comb begin
    an = 2'b11;
    case (r_state)
      S_SHOW_NEW: an = 2'b10;
      S_SHOW_OLD: an = 2'b01;
      default:    an = 2'b11;
    endcase
  end

  assign w_show_digit = (r_state == S_SHOW_NEW || r_state == S_BLANK_A) ? r_digit_new : r_digit_old;

  always_comb begin
    w_seg = 7'b1111111;
    case (w_show_digit)
      4'h0: w_seg = 7'b1000000;
      4'h1: w_seg = 7'b1111001;
      4'h2: w_seg = 7'b0100100;
      4'h3: w_seg = 7'b0110000;
      4'h4: w_seg = 7'b0011001;
      4'h5: w_seg = 7'b0010010;
      4'h6: w_seg = 7'b0000010;
      4'h7: w_seg = 7'b1111000;
      4'h8: w_seg = 7'b0000000;
      4'h9: w_seg = 7'b0010000;
      4'hA: w_seg = 7'b0001000;
      4'hB: w_seg = 7'b0000011;
      4'hC: w_seg = 7'b1000110;
      4'hD: w_seg = 7'b0100001;
      4'hE: w_seg = 7'b0000110;
      4'hF: w_seg = 7'b0001110;
      default: w_seg = 7'b1111111;
    endcase
  end

  assign seg       = w_seg;
  assign digit_new = r_digit_new;
  assign digit_old = r_digit_old;
  assign key_valid = r_key_valid;

endmodule
`default_nettype wire

// File: tb/tb_key_capture.sv
`default_nettype none
// ============================================================================
// Module  : tb_key_capture
// Purpose : Directed self-checking bench for key_capture (small mux/lockout).
// Rev     : 1.0  initial release
// ============================================================================
module tb_key_capture;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] row_pressed;
  logic [3:0] col;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_valid;
  logic [6:0] seg;
  logic [1:0] an;

  int n_tests;
  int n_fail;

  key_capture #(
    .MUX_DIV(24'd3),
    .DEAD   (8'd1),
    .LOCKOUT(24'd4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .row_pressed(row_pressed),
    .col        (col),
    .digit_new  (digit_new),
    .digit_old  (digit_old),
    .key_valid  (key_valid),
    .seg        (seg),
    .an         (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called just after a negedge: the next posedge samples the strobe.
  task automatic strobe(input logic [3:0] r, input logic [3:0] c);
    enable      = 1'b1;
    row_pressed = r;
    col         = c;
    @(negedge clk);
    enable      = 1'b0;
    row_pressed = 4'b0000;
    col         = 4'b0000;
  endtask

  task automatic check_keys(input string name, input logic kv, input logic [3:0] dn, input logic [3:0] dold);
    n_tests++;
    if (key_valid !== kv || digit_new !== dn || digit_old !== dold) begin
      n_fail++;
      $display("FAIL %s: got kv=%b new=%h old=%h, want kv=%b new=%h old=%h",
               name, key_valid, digit_new, digit_old, kv, dn, dold);
    end
  endtask

  task automatic wait_an_seg(input string name, input logic [1:0] want_an, input logic [6:0] want_seg);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (an === want_an) found = 1'b1;
      else @(negedge clk);
    end
    n_tests++;
    if (!found || seg !== want_seg) begin
      n_fail++;
      $display("FAIL %s: got an=%b seg=%b found=%0d, want an=%b seg=%b",
               name, an, seg, found, want_an, want_seg);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_tests++;
    if (digit_new !== 4'h0 || digit_old !== 4'h0 || key_valid !== 1'b0 || an !== 2'b10 || seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL reset_values: got new=%h old=%h kv=%b an=%b seg=%b, want 0 0 0 10 1000000",
               digit_new, digit_old, key_valid, an, seg);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_accept();
    strobe(4'b0001, 4'b0010);
    check_keys("accept_key2", 1'b1, 4'h2, 4'h0);
    @(negedge clk);
    check_keys("key_valid_one_pulse", 1'b0, 4'h2, 4'h0);
    wait_an_seg("seg_show_new_2", 2'b10, 7'b0100100);
  endtask

  task automatic test_lockout();
    repeat (4) @(negedge clk);
    strobe(4'b0010, 4'b0010);
    check_keys("accept_key5", 1'b1, 4'h5, 4'h2);
    @(negedge clk);
    strobe(4'b0100, 4'b0100);
    check_keys("lockout_ignore", 1'b0, 4'h5, 4'h2);
    @(negedge clk);
    strobe(4'b0100, 4'b0100);
    check_keys("accept_at_zero", 1'b1, 4'h9, 4'h5);
  endtask

  task automatic test_invalid();
    repeat (4) @(negedge clk);
    strobe(4'b0001, 4'b0110);
    check_keys("invalid_col", 1'b0, 4'h9, 4'h5);
    strobe(4'b0011, 4'b0001);
    check_keys("invalid_row", 1'b0, 4'h9, 4'h5);
    enable = 1'b0; row_pressed = 4'b0001; col = 4'b0001;
    @(negedge clk);
    row_pressed = 4'b0000; col = 4'b0000;
    check_keys("no_enable", 1'b0, 4'h9, 4'h5);
    strobe(4'b0001, 4'b0001);
    check_keys("no_lockout_after_invalid", 1'b1, 4'h1, 4'h9);
  endtask

  task automatic test_row3_sweep();
    logic [3:0] cols [4];
    logic [3:0] codes [4];
    logic [3:0] prev;
    cols  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    codes = '{4'hE, 4'h0, 4'hF, 4'hD};
    prev  = 4'h1;
    for (int i = 0; i < 4; i++) begin
      repeat (4) @(negedge clk);
      strobe(4'b1000, cols[i]);
      check_keys($sformatf("row3_col%0d", i), 1'b1, codes[i], prev);
      prev = codes[i];
    end
    wait_an_seg("seg_show_old_F", 2'b01, 7'b0001110);
    wait_an_seg("seg_show_new_D", 2'b10, 7'b0100001);
  endtask

  task automatic test_display_seq();
    logic [1:0] exp_an [8];
    exp_an = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b01, 2'b11};
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      n_tests++;
      if (an !== exp_an[i % 8]) begin
        n_fail++;
        $display("FAIL an_seq[%0d]: got %b, want %b", i, an, exp_an[i % 8]);
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    strobe(4'b0001, 4'b0100);
    repeat (4) @(negedge clk);
    strobe(4'b0100, 4'b0001);
    check_keys("setup_7_3", 1'b1, 4'h7, 4'h3);
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if (digit_new !== 4'h0 || digit_old !== 4'h0 || key_valid !== 1'b0 || an !== 2'b10 || seg !== 7'b1000000) begin
      n_fail++;
      $display("FAIL async_reset: got new=%h old=%h kv=%b an=%b seg=%b, want 0 0 0 10 1000000",
               digit_new, digit_old, key_valid, an, seg);
    end
    @(negedge clk);
    reset = 1'b0;
    strobe(4'b0010, 4'b0100);
    check_keys("strobe_at_reset_release", 1'b1, 4'h6, 4'h0);
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    enable      = 1'b0;
    row_pressed = 4'b0000;
    col         = 4'b0000;
    reset       = 1'b0;
    test_reset();
    test_accept();
    test_lockout();
    test_invalid();
    test_row3_sweep();
    test_display_seq();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
